maxnet_sequencer: RTL and testbench

- Control FSM that runs the MaxNet winner-take-all datapath: register-file read, Y load, PE multiply/sum and feedback loop.
- Repeats the multiply/sum/feedback loop until exactly one PE output is non-zero, then signals done.
- Adds a start/done handshake, a busy flag, an iteration counter and an optional iteration-limit timeout.
- Sits beside the datapath and drives its load/select strobes directly.

---
 rtl/maxnet_sequencer_if.sv | 44 ++++
 rtl/maxnet_sequencer.sv | 132 +++++++++++++
 tb/tb_maxnet_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/maxnet_sequencer_if.sv
// rtl/maxnet_sequencer_if.sv - start/done handshake and datapath strobe bundle for the MaxNet sequencer
interface maxnet_sequencer_if #(
    parameter int ITER_W = 8
);
    logic              start;
    logic              single_winner;
    logic              read;
    logic              select_y;
    logic              load_y;
    logic              load_mult;
    logic              load_sum;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [ITER_W-1:0] iter_count;

    modport master (
        input  start,
        input  single_winner,
        output read,
        output select_y,
        output load_y,
        output load_mult,
        output load_sum,
        output busy,
        output done,
        output timeout,
        output iter_count
    );

    modport slave (
        output start,
        output single_winner,
        input  read,
        input  select_y,
        input  load_y,
        input  load_mult,
        input  load_sum,
        input  busy,
        input  done,
        input  timeout,
        input  iter_count
    );
endinterface

// File: rtl/maxnet_sequencer.sv
// rtl/maxnet_sequencer.sv - MaxNet winner-take-all control FSM; MAXNET_SEQ_TIMEOUT_EN enables the MAX_ITER limit
module maxnet_sequencer #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 200
) (
    input  logic                clock,
    input  logic                reset,
    maxnet_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOADX,
        S_MULT,
        S_SUM,
        S_CHECK,
        S_FEEDBACK,
        S_DONE
    } state_e;

    localparam logic [ITER_W-1:0] ITER_SAT = '1;
`ifdef MAXNET_SEQ_TIMEOUT_EN
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER - 1);
`endif

    if (MAX_ITER < 1 || MAX_ITER > (2 ** ITER_W) - 1) begin : g_max_iter_range
        $error("maxnet_sequencer: MAX_ITER out of range for ITER_W");
    end

    state_e            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              timeout_q, timeout_d;

    logic read_s, select_y_s, load_y_s, load_mult_s, load_sum_s, busy_s, done_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            iter_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        timeout_d   = timeout_q;
        read_s      = 1'b0;
        select_y_s  = 1'b0;
        load_y_s    = 1'b0;
        load_mult_s = 1'b0;
        load_sum_s  = 1'b0;
        busy_s      = 1'b1;
        done_s      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy_s = 1'b0;
                if (bus.start) begin
                    state_d   = S_READ;
                    iter_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            S_READ: begin
                read_s  = 1'b1;
                state_d = S_LOADX;
            end
            S_LOADX: begin
                load_y_s = 1'b1;
                state_d  = S_MULT;
            end
            S_MULT: begin
                load_mult_s = 1'b1;
                state_d     = S_SUM;
            end
            S_SUM: begin
                load_sum_s = 1'b1;
                state_d    = S_CHECK;
            end
            // single_winner is only meaningful once the sum registers have settled
            S_CHECK: begin
                if (bus.single_winner) begin
                    state_d = S_DONE;
                end
`ifdef MAXNET_SEQ_TIMEOUT_EN
                else if (iter_q == ITER_LIMIT) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
`endif
                else begin
                    state_d = S_FEEDBACK;
                end
            end
            S_FEEDBACK: begin
                load_y_s   = 1'b1;
                select_y_s = 1'b1;
                state_d    = S_MULT;
                if (iter_q != ITER_SAT) begin
                    iter_d = iter_q + 1'b1;
                end
            end
            S_DONE: begin
                busy_s = 1'b0;
                done_s = 1'b1;
                if (bus.start) begin
                    state_d   = S_READ;
                    iter_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.read       = read_s;
    assign bus.select_y   = select_y_s;
    assign bus.load_y     = load_y_s;
    assign bus.load_mult  = load_mult_s;
    assign bus.load_sum   = load_sum_s;
    assign bus.busy       = busy_s;
    assign bus.done       = done_s;
    assign bus.timeout    = timeout_q;
    assign bus.iter_count = iter_q;
endmodule

// File: tb/tb_maxnet_sequencer.sv
// tb/tb_maxnet_sequencer.sv - randomized cycle-exact bench for maxnet_sequencer against a latency-formula model
module tb_maxnet_sequencer;
`ifdef MAXNET_SEQ_TIMEOUT_EN
    localparam int MAXI  = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MAXI  = 200;
    localparam bit TO_EN = 1'b0;
`endif
    localparam int IW  = 8;
    localparam int SAT = (1 << IW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    maxnet_sequencer_if #(.ITER_W(IW)) bus ();

    maxnet_sequencer #(.ITER_W(IW), .MAX_ITER(MAXI)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // {read, select_y, load_y, load_mult, load_sum, busy, done, timeout}
    function automatic logic [7:0] obs_vec();
        return {bus.read, bus.select_y, bus.load_y, bus.load_mult,
                bus.load_sum, bus.busy, bus.done, bus.timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle c counts from the cycle in which start is first sampled (c=0).
    function automatic logic [7:0] exp_vec(input int c, input int d, input logic to);
        if (c == d) return {6'b000000, 1'b1, to};
        if (c == 1) return 8'b1000_0100;
        if (c == 2) return 8'b0010_0100;
        case ((c - 3) % 4)
            0:       return 8'b0001_0100;
            1:       return 8'b0000_1100;
            2:       return 8'b0000_0100;
            default: return 8'b0110_0100;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    // A run whose winner appears at the k-th CHECK (k feedback loops first).
    task automatic run(input int k, input int tail);
        int   loops, d, it;
        logic to;
        to    = TO_EN && (k > MAXI - 1);
        loops = to ? MAXI - 1 : k;
        d     = 6 + 4 * loops;
        bus.start         = 1'b1;
        bus.single_winner = 1'($urandom);
        for (int c = 1; c <= d; c++) begin
            @(negedge clock);
            it = (c == d) ? sat(loops) : ((c < 3) ? 0 : sat((c - 3) / 4));
            check($sformatf("k%0d c%0d strobes", k, c), 32'(obs_vec()), 32'(exp_vec(c, d, to)));
            check($sformatf("k%0d c%0d iter", k, c), 32'(bus.iter_count), 32'(it));
            bus.start = (c < d) ? 1'($urandom) : 1'b0;
            if (c >= 5 && (c - 5) % 4 == 0)
                bus.single_winner = ((c - 5) / 4 == k);
            else
                bus.single_winner = 1'($urandom);
        end
        for (int t = 0; t < tail; t++) begin
            @(negedge clock);
            check($sformatf("k%0d hold%0d strobes", k, t), 32'(obs_vec()), 32'({6'b000000, 1'b1, to}));
            check($sformatf("k%0d hold%0d iter", k, t), 32'(bus.iter_count), 32'(sat(loops)));
            bus.start         = 1'b0;
            bus.single_winner = 1'($urandom);
        end
    endtask

    initial begin
        bus.start         = 1'b0;
        bus.single_winner = 1'b0;
        #1 reset = 1'b1;
        @(negedge clock);
        check("reset strobes", 32'(obs_vec()), 32'h0);
        check("reset iter", 32'(bus.iter_count), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.single_winner = 1'($urandom);
            check("idle strobes", 32'(obs_vec()), 32'h0);
        end
        bus.single_winner = 1'b0;

        run(0, 2);
        run(3, 1);
        for (int i = 0; i < 8; i++) begin
            run(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
        end
        run(10, 2);
        if (!TO_EN) begin
            run(260, 1);
        end
        run(0, 1);

        // Asynchronous reset landing mid-FEEDBACK
        bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            bus.start         = 1'b0;
            bus.single_winner = 1'b0;
        end
        check("pre-reset feedback strobes", 32'(obs_vec()), 32'(8'b0110_0100));
        #2 reset = 1'b1;
        #1;
        check("async reset strobes", 32'(obs_vec()), 32'h0);
        check("async reset iter", 32'(bus.iter_count), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("post-reset idle", 32'(obs_vec()), 32'h0);
        end
        run(2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
